// File: rtl/alu_result_if.sv
// Valid/ready result bus between the execute stage and the memory/writeback stage.
// The master drives valid and the payload. The slave drives ready.
interface alu_result_if #(
    parameter int N  = 32,
    parameter int RW = 4
);
    logic          valid;
    logic          ready;
    logic [N-1:0]  c;
    logic          cout;
    logic          zero;
    logic          overflow;
    logic          divz;
    logic [RW-1:0] rd;
    logic          wen;

    modport master (output valid, c, cout, zero, overflow, divz, rd, wen, input ready);
    modport slave  (input valid, c, cout, zero, overflow, divz, rd, wen, output ready);
endinterface

// File: rtl/alu_result_stage.sv
// Two-entry elastic buffer for execute-stage results, plus sticky status flags.
// in_ready comes from registered count only, so no combinational path runs from out_ready.
module alu_result_stage #(
    parameter int N  = 32,
    parameter int RW = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                clr_sticky,
    alu_result_if.slave         in_if,
    alu_result_if.master        out_if,
    output logic [3:0]          sticky,
    output logic [1:0]          occupancy
);
    typedef struct packed {
        logic [N-1:0]  c;
        logic          cout;
        logic          zero;
        logic          overflow;
        logic          divz;
        logic [RW-1:0] rd;
        logic          wen;
    } entry_t;

    entry_t     mem [2];
    logic       rd_ptr, wr_ptr;
    logic [1:0] count;
    logic       push, pop;
    entry_t     in_ent, head;

    assign in_if.ready = (count != 2'd2);
    assign push        = in_if.valid && in_if.ready;
    assign pop         = out_if.valid && out_if.ready;
    assign occupancy   = count;

    always_comb begin
        in_ent.c        = in_if.c;
        in_ent.cout     = in_if.cout;
        in_ent.zero     = in_if.zero;
        in_ent.overflow = in_if.overflow;
        in_ent.divz     = in_if.divz;
        in_ent.rd       = in_if.rd;
        in_ent.wen      = in_if.wen;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_ent;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            // A simultaneous push and pop leaves count unchanged.
            if (push && !pop)      count <= count + 2'd1;
            else if (pop && !push) count <= count - 2'd1;
        end
    end

    // A clear issued together with an accepted push keeps only the new flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sticky <= 4'b0;
        else if (clr_sticky && push && !flush)
            sticky <= {in_if.divz, in_if.overflow, in_if.cout, in_if.zero};
        else if (clr_sticky)
            sticky <= 4'b0;
        else if (push && !flush)
            sticky <= sticky | {in_if.divz, in_if.overflow, in_if.cout, in_if.zero};
    end

    assign head = mem[rd_ptr];

    always_comb begin
        out_if.valid    = (count != 2'd0);
        out_if.c        = '0;
        out_if.cout     = 1'b0;
        out_if.zero     = 1'b0;
        out_if.overflow = 1'b0;
        out_if.divz     = 1'b0;
        out_if.rd       = '0;
        out_if.wen      = 1'b0;
        if (out_if.valid) begin
            out_if.c        = head.c;
            out_if.cout     = head.cout;
            out_if.zero     = head.zero;
            out_if.overflow = head.overflow;
            out_if.divz     = head.divz;
            out_if.rd       = head.rd;
            out_if.wen      = head.wen;
        end
    end
endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage. Expected values are hand-computed.
// Inputs change 1ns after each rising edge, and outputs are checked at that same point.
module tb_alu_result_stage;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       clr_sticky = 1'b0;
    logic [3:0] sticky;
    logic [1:0] occupancy;
    int         vectors = 0;
    int         errs = 0;

    alu_result_if #(.N(32), .RW(4)) in_if ();
    alu_result_if #(.N(32), .RW(4)) out_if ();

    alu_result_stage #(.N(32), .RW(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .clr_sticky(clr_sticky),
        .in_if(in_if), .out_if(out_if), .sticky(sticky), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] c, input logic cout, input logic zero,
                         input logic ovf, input logic divz, input logic [3:0] rd, input logic wen);
        in_if.valid = v; in_if.c = c; in_if.cout = cout; in_if.zero = zero;
        in_if.overflow = ovf; in_if.divz = divz; in_if.rd = rd; in_if.wen = wen;
    endtask

    // Upstream must hold valid and data stable until the buffer accepts them.
    logic        pend = 1'b0;
    logic [31:0] pend_c;
    always @(negedge clk) begin
        if (pend && rst_n) begin
            assert (in_if.valid === 1'b1 && in_if.c === pend_c) else begin
                errs++;
                $error("FAIL upstream_hold: observed v=%0b c=%0h expected v=1 c=%0h", in_if.valid, in_if.c, pend_c);
            end
        end
        pend   = rst_n && in_if.valid && !in_if.ready && !flush;
        pend_c = in_if.c;
    end

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        out_if.ready = 1'b0;
        #3;
        chk("rst_out_valid", out_if.valid, 0);
        chk("rst_in_ready", in_if.ready, 1);
        chk("rst_sticky", sticky, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_out_wen", out_if.wen, 0);
        #4 rst_n = 1'b1;
        tick();

        // 1: single push. It is visible after the push edge and popped at the next edge.
        drive(1, 32'h7, 0, 0, 0, 0, 4'd3, 1);
        out_if.ready = 1'b1;
        tick();
        chk("t1_valid", out_if.valid, 1);
        chk("t1_c", out_if.c, 32'h7);
        chk("t1_rd", out_if.rd, 3);
        chk("t1_wen", out_if.wen, 1);
        chk("t1_occ1", occupancy, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("t1_occ0", occupancy, 0);
        chk("t1_masked_c", out_if.c, 0);
        chk("t1_sticky", sticky, 0);

        // 2: fill while stalled, then drain in order.
        out_if.ready = 1'b0;
        drive(1, 32'h11, 0, 0, 0, 0, 4'd1, 1);
        tick();
        drive(1, 32'h22, 0, 0, 0, 0, 4'd2, 1);
        tick();
        chk("t2_occ2", occupancy, 2);
        chk("t2_in_ready", in_if.ready, 0);
        drive(1, 32'h33, 0, 0, 0, 0, 4'd3, 1);
        tick();
        chk("t2_hold_occ", occupancy, 2);
        chk("t2_hold_c", out_if.c, 32'h11);
        out_if.ready = 1'b1;
        tick();
        chk("t2_pop1_c", out_if.c, 32'h22);
        chk("t2_pop1_occ", occupancy, 1);
        tick();
        chk("t2_pop2_c", out_if.c, 32'h33);
        chk("t2_pop2_occ", occupancy, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("t2_empty", occupancy, 0);

        // 3: push and pop together at count 1.
        out_if.ready = 1'b0;
        drive(1, 32'hA, 0, 0, 0, 0, 4'd4, 1);
        tick();
        chk("t3_head_a", out_if.c, 32'hA);
        drive(1, 32'hB, 0, 0, 0, 0, 4'd5, 1);
        out_if.ready = 1'b1;
        tick();
        chk("t3_occ", occupancy, 1);
        chk("t3_head_b", out_if.c, 32'hB);
        chk("t3_rd_b", out_if.rd, 5);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("t3_empty", occupancy, 0);

        // 4: flags accumulate; a clear issued with a push keeps only the new flags.
        drive(1, 32'h0, 0, 1, 0, 1, 4'd6, 1);
        tick();
        drive(1, 32'h5, 0, 0, 1, 0, 4'd7, 1);
        tick();
        chk("t4_sticky_or", sticky, 4'b1101);
        clr_sticky = 1'b1;
        drive(1, 32'h9, 1, 0, 0, 0, 4'd8, 1);
        tick();
        chk("t4_sticky_clrpush", sticky, 4'b0010);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("t4_sticky_clr", sticky, 0);
        clr_sticky = 1'b0;
        tick();
        chk("t4_drained", occupancy, 0);

        // 5: flush while full. Flush wins over a simultaneous push and pop.
        out_if.ready = 1'b0;
        drive(1, 32'h55, 0, 1, 0, 0, 4'd9, 1);
        tick();
        drive(1, 32'h66, 0, 0, 0, 0, 4'd10, 1);
        tick();
        chk("t5_full", occupancy, 2);
        flush = 1'b1;
        out_if.ready = 1'b1;
        drive(1, 32'h77, 1, 0, 1, 1, 4'd11, 1);
        tick();
        chk("t5_occ", occupancy, 0);
        chk("t5_valid", out_if.valid, 0);
        chk("t5_wen", out_if.wen, 0);
        chk("t5_c", out_if.c, 0);
        chk("t5_sticky", sticky, 4'b0001);
        flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("t5_absent", occupancy, 0);

        // 6: an asynchronous reset while full takes effect before the next edge.
        out_if.ready = 1'b0;
        drive(1, 32'h88, 0, 0, 1, 0, 4'd12, 1);
        tick();
        drive(1, 32'h99, 0, 0, 0, 0, 4'd13, 1);
        tick();
        chk("t6_full", occupancy, 2);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_valid", out_if.valid, 0);
        chk("t6_in_ready", in_if.ready, 1);
        chk("t6_sticky", sticky, 0);
        chk("t6_occ", occupancy, 0);
        #3 rst_n = 1'b1;
        tick();
        chk("t6_post_occ", occupancy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- 2-entry elastic result buffer directly downstream of the execute-stage arithmetic units, including the modulo unit.
- Captures a result word, its flags (cout, zero, overflow), a divide-by-zero indication and writeback tag, then hands them to the memory/writeback stage over a valid/ready handshake.
- Decouples execute from downstream stalls without a combinational ready path.
- Also keeps sticky status flags readable by the control unit.

Parameters:
- N, 32, result data width (matches the arithmetic unit width).
- RW, 4, destination register address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- flush  in  1  synchronous pipeline flush; discards all buffered entries.
- in_valid  in  1  upstream result valid.
- in_ready  out  1  buffer can accept; a push occurs when in_valid && in_ready.
- in_c  in  N  result word from the arithmetic unit.
- in_cout  in  1  carry flag.
- in_zero  in  1  zero flag.
- in_overflow  in  1  overflow flag.
- in_divz  in  1  divisor was zero (high when operand b == 0 on a div/mod op).
- in_rd  in  RW  destination register.
- in_wen  in  1  register write enable for this result.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts; a pop occurs when out_valid && out_ready.
- out_c  out  N  head result.
- out_cout, out_zero, out_overflow, out_divz  out  1 each  head flags.
- out_rd  out  RW  head destination register.
- out_wen  out  1  head write enable; forced 0 when out_valid=0.
- sticky  out  4  {divz, overflow, cout, zero}, ORed over accepted pushes.
- clr_sticky  in  1  synchronous clear of sticky.
- occupancy  out  2  entries held (0..2).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - count=0, read/write pointers=0, storage cleared.
  - out_valid=0, in_ready=1, all out_* =0, sticky=0, occupancy=0.
- Storage: 2-entry circular FIFO, 1-bit rd_ptr/wr_ptr, 2-bit count. Entry is {c, cout, zero, overflow, divz, rd, wen}, N+RW+5 bits.
- in_ready = (count != 2). It is derived from registered state only; it never depends on out_ready.
- out_valid = (count != 0). out_* driven from entry[rd_ptr] when valid; all out_* forced 0 when count==0.
- Latency: an entry pushed at edge k is visible on out_* after edge k (earliest pop at edge k+1). There is no same-cycle bypass.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together (count==1): count unchanged, both pointers advance.
  - count==2: push impossible; pop -> 1.
- Ordering: strict FIFO. Pointers wrap 1->0.
- flush=1 at an edge:
  - count=0, rd_ptr=wr_ptr=0.
  - Any simultaneous push and pop are ignored; flush dominates.
  - Storage contents are don't-care but outputs are masked to 0.
- Sticky:
  - On an accepted push (and no flush), sticky |= {in_divz, in_overflow, in_cout, in_zero}.
  - clr_sticky alone -> sticky=0.
  - clr_sticky together with an accepted push -> sticky = the new push's flags only.
  - flush does not modify sticky.
- occupancy = count.
- Holding: while out_valid && !out_ready, all out_* stay stable.
- Behaviour is undefined if upstream drops in_valid or changes data before acceptance; the bench asserts on this.
- Reset mid-operation: immediate return to the reset state; buffered entries are lost.

Test Plan:
1. Reset, then push {c=0x00000007, zero=0, rd=3, wen=1} with out_ready=1 -> out_valid rises the next cycle with out_c=0x7, out_rd=3, occupancy 1 then 0. sticky=0000.
2. out_ready=0, push 0x11, 0x22, then offer 0x33 -> in_ready=0 after the second push, occupancy=2, 0x33 held upstream. Raise out_ready -> pops in order 0x11, 0x22, 0x33.
3. count=1 (head 0xA), simultaneous push 0xB and pop -> occupancy stays 1, next out_c=0xB, no loss or duplication.
4. Push {c=0, zero=1, divz=1} then {c=5, overflow=1} -> sticky=1101. Assert clr_sticky with a push {cout=1} -> sticky=0010.
5. occupancy=2, assert flush with in_valid=1 and out_ready=1 -> occupancy=0, out_valid=0, out_wen=0, pushed data absent. sticky unchanged.
6. occupancy=2, drive rst_n low between edges -> out_valid=0, in_ready=1, sticky=0 immediately, before the next clk edge.
